// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - funct3 encodings and state encoding for the RV32M multiply/divide unit
package mul_div_unit_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_STATE_IDLE = 2'd0,
        MD_STATE_MUL  = 2'd1,
        MD_STATE_DIV  = 2'd2,
        MD_STATE_FIN  = 2'd3
    } md_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative radix-2 RV32M multiply/divide unit with registered writeback
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wr_addr,
    output logic            wr_en
);

    localparam int         W2        = 2 * XLEN;
    localparam logic [5:0] ITER_LAST = 6'(ITER);

    function automatic logic [W2-1:0] sign_fix(input logic [W2-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    md_state_e         state_q, state_d;
    logic [W2-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              spec_q, spec_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        wr_addr_q, wr_addr_d;
    logic              wr_en_q, wr_en_d;

    logic              a_sgn, b_sgn, div_zero, div_ovf, ge;
    logic [XLEN-1:0]   a_mag, b_mag, rem_nx, fin_res;
    logic [XLEN:0]     mul_sum, rem_sh;
    logic [W2-1:0]     step, fix_src, fixed;

    // Datapath: magnitudes at accept, one shift-add or restoring step per cycle, sign fix at finish
    always_comb begin
        a_sgn    = rs1[XLEN-1] & (op != MD_MULHU) & ~(op[2] & op[0]);
        b_sgn    = rs2[XLEN-1] & ((op == MD_MUL) | (op == MD_MULH) | (op == MD_DIV) | (op == MD_REM));
        a_mag    = a_sgn ? -rs1 : rs1;
        b_mag    = b_sgn ? -rs2 : rs2;
        div_zero = (rs2 == '0);
        div_ovf  = ~op[0] & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);

        mul_sum = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh  = acc_q[W2-1:XLEN-1];
        ge      = (rem_sh >= {1'b0, opb_q});
        rem_nx  = XLEN'(rem_sh - (ge ? {1'b0, opb_q} : '0));
        if (state_q == MD_STATE_MUL) begin
            step = {mul_sum, acc_q[XLEN-1:1]};
        end else begin
            step = {rem_nx, acc_q[XLEN-2:0], ge};
        end

        fix_src = (op_q[2] == 1'b0) ? acc_q
                : {{XLEN{1'b0}}, (op_q[1] ? acc_q[W2-1:XLEN] : acc_q[XLEN-1:0])};
        fixed   = sign_fix(fix_src, neg_q);
        if (spec_q) begin
            fin_res = acc_q[XLEN-1:0];
        end else if ((op_q == MD_MUL) || op_q[2]) begin
            fin_res = fixed[XLEN-1:0];
        end else begin
            fin_res = fixed[W2-1:XLEN];
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        op_d      = op_q;
        neg_d     = neg_q;
        spec_d    = spec_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        wr_addr_d = wr_addr_q;
        wr_en_d   = 1'b0;
        case (state_q)
            MD_STATE_IDLE: begin
                if (start && !flush) begin
                    op_d      = op;
                    wr_addr_d = rd_addr;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    spec_d    = 1'b0;
                    neg_d     = a_sgn ^ (b_sgn & ~(op[2] & op[1]));
                    if (!op[2]) begin
                        state_d = MD_STATE_MUL;
                        acc_d   = {{XLEN{1'b0}}, b_mag};
                        opb_d   = a_mag;
                    end else begin
                        state_d = MD_STATE_DIV;
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        opb_d   = b_mag;
                        // Special cases park the answer in acc and finish after one cycle
                        if (div_zero || div_ovf) begin
                            spec_d = 1'b1;
                            cnt_d  = ITER_LAST;
                            if (div_zero) begin
                                acc_d = {{XLEN{1'b0}}, (op[1] ? rs1 : {XLEN{1'b1}})};
                            end else begin
                                acc_d = {{XLEN{1'b0}}, (op[1] ? {XLEN{1'b0}} : rs1)};
                            end
                        end
                    end
                end
            end
            MD_STATE_MUL, MD_STATE_DIV: begin
                if (flush) begin
                    state_d = MD_STATE_IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == ITER_LAST) begin
                    state_d  = MD_STATE_FIN;
                    done_d   = 1'b1;
                    result_d = fin_res;
                    wr_en_d  = (wr_addr_q != 5'd0);
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = MD_STATE_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= MD_STATE_IDLE;
            acc_q     <= '0;
            opb_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            spec_q    <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            wr_addr_q <= '0;
            wr_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            spec_q    <= spec_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            wr_addr_q <= wr_addr_d;
            wr_en_q   <= wr_en_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign wr_addr = wr_addr_q;
    assign wr_en   = wr_en_q;

endmodule
